// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the pointed port.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Grant vector is purely combinational; the pointer only matters on a tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt            = 2'b00;
            gnt[PORT_CORE] = (ptr == PORT_CORE);
            gnt[PORT_DMA]  = (ptr == PORT_DMA);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (port 0) and DMA/debug (port 1).
// Each access takes three cycles: IDLE (arbitrate and latch), ACCESS (drive dmem), DONE (pulse done).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t            state;
    state_t            state_nx;
    logic              rr_ptr;
    logic [1:0]        gnt;
    logic              winner;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;

    rr_arb2 u_arb (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign winner   = gnt[PORT_DMA];
    assign in_range = (lat_addr < ADDR_W'(DEPTH));

    // State register; reset drops any access in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the winning request in IDLE so requesters only need stable inputs for that one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_id    <= PORT_CORE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rr_ptr    <= PORT_CORE;
        end else if (state == IDLE && req_i != 2'b00) begin
            lat_id    <= winner;
            lat_we    <= we_i[winner];
            lat_addr  <= (winner == PORT_DMA) ? addr1_i : addr0_i;
            lat_wdata <= (winner == PORT_DMA) ? wdata1_i : wdata0_i;
            rr_ptr    <= ~winner;
        end
    end

    // Capture read data at the end of ACCESS; writes and out-of-range accesses leave zero behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o <= '0;
        end else if (state == ACCESS) begin
            rdata_o <= (!lat_we && in_range) ? mem_rdata_i : '0;
        end
    end

    // Next-state and output decode; memory strobes are suppressed for out-of-range addresses.
    always_comb begin
        state_nx    = state;
        done_o      = 2'b00;
        err_o       = 1'b0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o  = lat_addr;
                mem_wdata_o = lat_wdata;
                mem_rd_o    = in_range && !lat_we;
                mem_wr_o    = in_range && lat_we;
                state_nx    = DONE;
            end
            DONE: begin
                done_o[lat_id] = 1'b1;
                err_o          = !in_range;
                state_nx       = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        done_o;
    logic              err_o;
    logic [DATA_W-1:0] rdata_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic              mem_wr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    int check_count = 0;
    int pass_count  = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Data memory stand-in: combinational read, write at posedge, indexed by low address bits.
    logic [DATA_W-1:0] dmem [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_o) dmem[mem_addr_o[4:0]] <= mem_wdata_o;
    end
    assign mem_rdata_i = dmem[mem_addr_o[4:0]];

    // Reference model: one granted transaction at a time, timed from its grant edge.
    int                m_edge  = 0;
    int                m_g     = 0;
    bit                m_valid = 1'b0;
    logic              m_port  = 1'b0;
    logic              m_we    = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              m_rr    = 1'b0;
    logic [DATA_W-1:0] shadow [DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_rr    = 1'b0;
            m_rdata = '0;
        end else begin
            m_edge++;
            if (m_valid && m_edge == m_g + 1) begin
                if (m_addr < ADDR_W'(DEPTH) && !m_we) m_rdata = shadow[m_addr[4:0]];
                else m_rdata = '0;
                if (m_addr < ADDR_W'(DEPTH) && m_we) shadow[m_addr[4:0]] = m_wdata;
            end
            if (!m_valid || m_edge >= m_g + 3) begin
                if (req_i != 2'b00) begin
                    m_port  = (req_i == 2'b11) ? m_rr : req_i[1];
                    m_we    = we_i[m_port];
                    m_addr  = m_port ? addr1_i : addr0_i;
                    m_wdata = m_port ? wdata1_i : wdata0_i;
                    m_rr    = !m_port;
                    m_g     = m_edge;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [1:0]        e_done;
        logic              e_err, e_rd, e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic              oor;
        e_done = 2'b00; e_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
        oor = !(m_addr < ADDR_W'(DEPTH));
        if (rst_n && m_valid && m_edge == m_g) begin
            e_rd    = !oor && !m_we;
            e_wr    = !oor && m_we;
            e_addr  = m_addr;
            e_wdata = m_wdata;
        end
        if (rst_n && m_valid && m_edge == m_g + 1) begin
            e_done = m_port ? 2'b10 : 2'b01;
            e_err  = oor;
        end
        checkOutput("model_done",  {30'd0, done_o}, {30'd0, e_done});
        checkOutput("model_err",   {31'd0, err_o}, {31'd0, e_err});
        checkOutput("model_rdwr",  {30'd0, mem_rd_o, mem_wr_o}, {30'd0, e_rd, e_wr});
        checkOutput("model_addr",  mem_addr_o, e_addr);
        checkOutput("model_wdata", mem_wdata_o, e_wdata);
        checkOutput("model_rdata", rdata_o, m_rdata);
    end

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic [31:0] a1, input logic [31:0] d1);
        req_i = r; we_i = w; addr0_i = a0; wdata0_i = d0; addr1_i = a1; wdata1_i = d1;
    endtask

    // Bounded wait for a done pulse; reports cycles taken and write strobes seen on the way.
    task automatic waitDone(output logic [1:0] d, output int n, output logic e,
                            output logic [31:0] rd, output int wrc);
        d = 2'b00; n = 0; e = 1'b0; rd = '0; wrc = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (mem_wr_o) wrc++;
            if (done_o != 2'b00) begin
                d = done_o; e = err_o; rd = rdata_o;
                return;
            end
        end
        check_count++;
        $display("[TB] FAIL done_timeout: no done pulse within %0d cycles", n);
    endtask

    logic [1:0]  d;
    logic        e;
    logic [31:0] rd;
    int          n, wrc, cnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dmem[i]   = '0;
            shadow[i] = '0;
        end
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset_done",  {30'd0, done_o}, 32'd0);
        checkOutput("reset_rdwr",  {30'd0, mem_rd_o, mem_wr_o}, 32'd0);
        checkOutput("reset_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous reads after reset: port 0 first, port 1 three cycles later.
        applyStimulus(2'b11, 2'b00, 7, 0, 9, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t2_first", {30'd0, d}, 32'h1);
        checkOutput("t2_lat0", n, 32'd2);
        applyStimulus(2'b10, 2'b00, 7, 0, 9, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t2_second", {30'd0, d}, 32'h2);
        checkOutput("t2_lat1", n, 32'd3);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);

        // Continuous contention: six grants alternating 01,10,...
        applyStimulus(2'b11, 2'b00, 1, 0, 2, 0);
        for (int i = 0; i < 6; i++) begin
            waitDone(d, n, e, rd, wrc);
            checkOutput("t3_order", {30'd0, d}, (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("t3_lat", n, (i == 0) ? 32'd2 : 32'd3);
        end
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);

        // Write then read back through port 0.
        applyStimulus(2'b01, 2'b01, 5, 32'hDEADBEEF, 0, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t1_wdone", {30'd0, d}, 32'h1);
        checkOutput("t1_wlat", n, 32'd2);
        checkOutput("t1_wrcnt", wrc, 32'd1);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(2'b01, 2'b00, 5, 0, 0, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t1_rdone", {30'd0, d}, 32'h1);
        checkOutput("t1_rdata", rd, 32'hDEADBEEF);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);

        // Out-of-range write aliasing onto addr 8 must not disturb it.
        applyStimulus(2'b10, 2'b10, 0, 0, 8, 32'hA5A5A5A5);
        waitDone(d, n, e, rd, wrc);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(2'b10, 2'b10, 0, 0, 40, 32'h12345678);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t4_done", {30'd0, d}, 32'h2);
        checkOutput("t4_err", {31'd0, e}, 32'd1);
        checkOutput("t4_wrcnt", wrc, 32'd0);
        checkOutput("t4_rdata", rd, 32'd0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(2'b01, 2'b00, 8, 0, 0, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t4_readback", rd, 32'hA5A5A5A5);
        checkOutput("t4_rderr", {31'd0, e}, 32'd0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);

        // One-cycle request pulse still completes exactly once.
        applyStimulus(2'b01, 2'b00, 5, 0, 0, 0);
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t6_done", {30'd0, d}, 32'h1);
        checkOutput("t6_lat", n, 32'd1);
        checkOutput("t6_rdata", rd, 32'hDEADBEEF);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o != 2'b00 || mem_rd_o || mem_wr_o) cnt++;
        end
        checkOutput("t6_no_repeat", cnt, 32'd0);

        // Reset during a write ACCESS: outputs clear at once, no done, pointer back to port 0.
        applyStimulus(2'b01, 2'b01, 3, 32'h55AA55AA, 0, 0);
        @(negedge clk);
        checkOutput("t5_wr_active", {31'd0, mem_wr_o}, 32'd1);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rdwr", {30'd0, mem_rd_o, mem_wr_o}, 32'd0);
        checkOutput("t5_addr", mem_addr_o, 32'd0);
        checkOutput("t5_wdata", mem_wdata_o, 32'd0);
        checkOutput("t5_rdata", rdata_o, 32'd0);
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done_o != 2'b00) cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_o != 2'b00) cnt++;
        end
        checkOutput("t5_no_done", cnt, 32'd0);
        applyStimulus(2'b11, 2'b00, 3, 0, 5, 0);
        waitDone(d, n, e, rd, wrc);
        checkOutput("t5_ptr", {30'd0, d}, 32'h1);
        checkOutput("t5_unwritten", rd, 32'd0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
